cond_flags_stage: RTL and testbench
===================================

COND_FLAGS_STAGE -- requirements
Module: cond_flags_stage

Interface
REQ-001 Parameter N, default 64, datapath width of the result.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  upstream ALU stage holds a valid instruction.
REQ-005 o_ready  output  1  stage accepts input this cycle.
REQ-006 i_result  input  N  ALU result.
REQ-007 i_nzcv  input  4  ALU flags: [0]=N, [1]=Z, [2]=C, [3]=V.
REQ-008 i_set_flags  input  1  instruction writes the flag register.
REQ-009 i_is_bcond  input  1  instruction is a conditional branch.
REQ-010 i_cond  input  4  condition code for the branch.
REQ-011 o_valid  output  1  output register holds a valid instruction.
REQ-012 i_ready  input  1  downstream accepts output this cycle.
REQ-013 o_result  output  N  registered result.
REQ-014 o_taken  output  1  registered branch-taken decision.
REQ-015 o_flags  output  4  current architectural flag register, same bit order as i_nzcv.
REQ-016 o_taken_cnt  output  16  saturating count of taken branches.

Function
REQ-017 Input transfer SHALL occur when i_valid and o_ready are both 1; output transfer SHALL occur when o_valid and i_ready are both 1.
REQ-018 o_ready SHALL equal (not o_valid) or i_ready; this is a single-entry output register with no combinational path from i_valid to o_ready.
REQ-019 Latency SHALL be 1 cycle: an input transfer at edge k makes o_valid=1 with its o_result and o_taken after edge k.
REQ-020 While o_valid=1 and i_ready=0, o_result, o_taken and o_valid SHALL hold their values.
REQ-021 Simultaneous output and input transfer SHALL load the new instruction with no bubble; an output transfer without an input transfer SHALL clear o_valid.
REQ-022 On input transfer with i_set_flags=1, the flag register SHALL load i_nzcv; otherwise it SHALL hold.
REQ-023 The condition SHALL be evaluated against the flag register value before the same edge's update, so an instruction with both i_set_flags and i_is_bcond uses the old flags.
REQ-024 o_taken SHALL be loaded with i_is_bcond AND cond_true.
REQ-025 cond_true SHALL follow this mapping: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !(C&!Z); 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 !(!Z&(N==V)); 1110 and 1111 always true.
REQ-026 o_taken_cnt SHALL increment by 1 on each input transfer that loads o_taken=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-027 With no input transfer, the flag register and o_taken_cnt SHALL hold.

Reset
REQ-028 When i_rst_n=0, the following SHALL be forced immediately and independently of i_clk: o_valid=0, o_result=0, o_taken=0, flag register=4'b0000, o_taken_cnt=0.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction.
REQ-030 The first input transfer SHALL be possible on the first rising edge after i_rst_n deasserts.

Structure
REQ-031 Package cond_pkg SHALL hold the 4-bit condition-code enum (EQ..AL, NV) and the flag bit-index constants (FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3).
REQ-032 Condition evaluation SHALL be a combinational sub-module cond_eval (inputs: 4-bit flags and cond; output: cond_true), instantiated once.

Verification
REQ-033 The bench SHALL cover: load flags with i_nzcv=4'b0010 (Z=1) and set_flags=1, then bcond cond=0000 -> o_taken=1; then cond=0001 -> o_taken=0.
REQ-034 The bench SHALL cover: a single instruction with set_flags=1, i_nzcv=4'b0000, bcond cond=0000, while flags hold Z=1 -> o_taken=1 (old flags used), and o_flags=0000 afterwards.
REQ-035 The bench SHALL cover: flags N=1,V=0 with cond 1011 -> taken and cond 1010 -> not taken; flags C=1,Z=0 with cond 1000 -> taken.
REQ-036 The bench SHALL cover: i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0 and o_result stable; then i_ready=1 for back-to-back transfers -> one result per cycle, no bubble.
REQ-037 The bench SHALL cover: 65537 taken branches -> o_taken_cnt=16'hFFFF, no wrap.
REQ-038 The bench SHALL cover: i_rst_n pulsed low during a stall -> o_valid=0, o_flags=0000 and o_taken_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/cond_flags_stage_pkg.sv
// Shared condition-code encoding and flag bit positions for the
// condition/flags pipeline stage.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/cond_flags_stage_if.sv
// Valid/ready bus around the condition/flags stage: upstream ALU side
// (i_*) and downstream side (o_*), named as seen by the stage.
interface cond_flags_stage_if #(
  parameter int unsigned N = 64
) ();
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_result;
  logic [3:0]   i_nzcv;
  logic         i_set_flags;
  logic         i_is_bcond;
  logic [3:0]   i_cond;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic         o_taken;
  logic [3:0]   o_flags;
  logic [15:0]  o_taken_cnt;

  modport master (
    output i_valid, i_result, i_nzcv, i_set_flags, i_is_bcond, i_cond, i_ready,
    input  o_ready, o_valid, o_result, o_taken, o_flags, o_taken_cnt
  );

  modport slave (
    input  i_valid, i_result, i_nzcv, i_set_flags, i_is_bcond, i_cond, i_ready,
    output o_ready, o_valid, o_result, o_taken, o_flags, o_taken_cnt
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code evaluation against a 4-bit NZCV flag word.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_true
);
  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    cond_true = 1'b1;
    case (cond_e'(cond))
      EQ: cond_true = z;
      NE: cond_true = !z;
      CS: cond_true = c;
      CC: cond_true = !c;
      MI: cond_true = n;
      PL: cond_true = !n;
      VS: cond_true = v;
      VC: cond_true = !v;
      HI: cond_true = c && !z;
      LS: cond_true = !(c && !z);
      GE: cond_true = (n == v);
      LT: cond_true = (n != v);
      GT: cond_true = !z && (n == v);
      LE: cond_true = !(!z && (n == v));
      default: cond_true = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_flags_stage.sv
// Single-entry pipeline stage: registers the ALU result, maintains the
// architectural flag register and resolves conditional branches.
module cond_flags_stage
  import cond_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input logic               i_clk,
  input logic               i_rst_n,
  cond_flags_stage_if.slave bus
);
  logic         valid_q, valid_d;
  logic [N-1:0] result_q, result_d;
  logic         taken_q, taken_d;
  logic [3:0]   flags_q, flags_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         ready, in_xfer, out_xfer, cond_true, taken_new;

  // Evaluated on the registered flags, so a flag-setting branch sees old flags.
  cond_eval u_cond_eval (
    .flags     (flags_q),
    .cond      (bus.i_cond),
    .cond_true (cond_true)
  );

  always_comb begin
    ready     = !valid_q || bus.i_ready;
    in_xfer   = bus.i_valid && ready;
    out_xfer  = valid_q && bus.i_ready;
    taken_new = bus.i_is_bcond && cond_true;

    valid_d  = valid_q;
    result_d = result_q;
    taken_d  = taken_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;

    if (in_xfer) begin
      valid_d  = 1'b1;
      result_d = bus.i_result;
      taken_d  = taken_new;
      if (bus.i_set_flags) flags_d = bus.i_nzcv;
      if (taken_new && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      taken_q  <= 1'b0;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_result    = result_q;
  assign bus.o_taken     = taken_q;
  assign bus.o_flags     = flags_q;
  assign bus.o_taken_cnt = cnt_q;
endmodule

// File: tb/tb_cond_flags_stage.sv
// Directed bench for cond_flags_stage with hand-computed expectations.
module tb_cond_flags_stage;
  logic i_clk;
  logic i_rst_n;
  int   passed;
  int   failed;
  int   total;

  cond_flags_stage_if #(.N(64)) bus ();

  cond_flags_stage #(.N(64)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [3:0] nzcv,
                       input logic sf, input logic bc, input logic [3:0] cond);
    bus.i_valid     = v;
    bus.i_result    = res;
    bus.i_nzcv      = nzcv;
    bus.i_set_flags = sf;
    bus.i_is_bcond  = bc;
    bus.i_cond      = cond;
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    i_rst_n = 1'b0;
    bus.i_ready = 1'b1;
    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 4'h0);

    @(negedge i_clk);
    check("rst_valid",  {63'b0, bus.o_valid}, 64'd0);
    check("rst_result", bus.o_result, 64'd0);
    check("rst_taken",  {63'b0, bus.o_taken}, 64'd0);
    check("rst_flags",  {60'b0, bus.o_flags}, 64'd0);
    check("rst_cnt",    {48'b0, bus.o_taken_cnt}, 64'd0);
    check("rst_ready",  {63'b0, bus.o_ready}, 64'd1);
    i_rst_n = 1'b1;

    // Z=1 into flags, then EQ / NE branches
    drive(1'b1, 64'h11, 4'b0010, 1'b1, 1'b0, 4'h0); step();
    check("load_valid",  {63'b0, bus.o_valid}, 64'd1);
    check("load_result", bus.o_result, 64'h11);
    check("load_flags",  {60'b0, bus.o_flags}, 64'b0010);
    check("load_taken",  {63'b0, bus.o_taken}, 64'd0);
    drive(1'b1, 64'h22, 4'h0, 1'b0, 1'b1, 4'b0000); step();
    check("eq_taken", {63'b0, bus.o_taken}, 64'd1);
    check("eq_cnt",   {48'b0, bus.o_taken_cnt}, 64'd1);
    drive(1'b1, 64'h33, 4'h0, 1'b0, 1'b1, 4'b0001); step();
    check("ne_taken", {63'b0, bus.o_taken}, 64'd0);
    check("ne_cnt",   {48'b0, bus.o_taken_cnt}, 64'd1);

    // set_flags + bcond together uses old flags (Z=1)
    drive(1'b1, 64'h44, 4'b0000, 1'b1, 1'b1, 4'b0000); step();
    check("old_flags_taken", {63'b0, bus.o_taken}, 64'd1);
    check("old_flags_after", {60'b0, bus.o_flags}, 64'b0000);
    check("old_flags_cnt",   {48'b0, bus.o_taken_cnt}, 64'd2);

    // N=1, V=0: LT taken, GE not
    drive(1'b1, 64'h55, 4'b0001, 1'b1, 1'b0, 4'h0); step();
    drive(1'b1, 64'h56, 4'h0, 1'b0, 1'b1, 4'b1011); step();
    check("lt_taken", {63'b0, bus.o_taken}, 64'd1);
    drive(1'b1, 64'h57, 4'h0, 1'b0, 1'b1, 4'b1010); step();
    check("ge_taken", {63'b0, bus.o_taken}, 64'd0);
    check("ge_cnt",   {48'b0, bus.o_taken_cnt}, 64'd3);

    // C=1, Z=0: HI taken, LS not, AL taken, CS taken
    drive(1'b1, 64'h60, 4'b0100, 1'b1, 1'b0, 4'h0); step();
    drive(1'b1, 64'h61, 4'h0, 1'b0, 1'b1, 4'b1000); step();
    check("hi_taken", {63'b0, bus.o_taken}, 64'd1);
    drive(1'b1, 64'h62, 4'h0, 1'b0, 1'b1, 4'b1001); step();
    check("ls_taken", {63'b0, bus.o_taken}, 64'd0);
    drive(1'b1, 64'h63, 4'h0, 1'b0, 1'b1, 4'b1110); step();
    check("al_taken", {63'b0, bus.o_taken}, 64'd1);
    drive(1'b1, 64'h64, 4'h0, 1'b0, 1'b1, 4'b0010); step();
    check("cs_taken", {63'b0, bus.o_taken}, 64'd1);
    check("cs_cnt",   {48'b0, bus.o_taken_cnt}, 64'd6);

    // No input transfer: flags and count hold, output drains
    drive(1'b0, 64'h65, 4'b1111, 1'b1, 1'b1, 4'b1110); step();
    check("idle_valid", {63'b0, bus.o_valid}, 64'd0);
    check("idle_flags", {60'b0, bus.o_flags}, 64'b0100);
    check("idle_cnt",   {48'b0, bus.o_taken_cnt}, 64'd6);

    // Stall for 3 cycles, then back-to-back drain
    bus.i_ready = 1'b0;
    drive(1'b1, 64'hA1, 4'h0, 1'b0, 1'b0, 4'h0); step();
    check("stall_load", bus.o_result, 64'hA1);
    drive(1'b1, 64'hA2, 4'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready",  {63'b0, bus.o_ready}, 64'd0);
      check("stall_result", bus.o_result, 64'hA1);
      check("stall_valid",  {63'b0, bus.o_valid}, 64'd1);
    end
    bus.i_ready = 1'b1;
    #1;
    check("unstall_ready", {63'b0, bus.o_ready}, 64'd1);
    @(negedge i_clk);
    for (int i = 2; i <= 4; i++) begin
      step();
      check("b2b_result", bus.o_result, 64'hA0 + 64'(i));
      check("b2b_valid",  {63'b0, bus.o_valid}, 64'd1);
      drive(1'b1, 64'hA0 + 64'(i + 1), 4'h0, 1'b0, 1'b0, 4'h0);
    end

    // Reset asserted mid-stall
    bus.i_ready = 1'b0;
    step();
    check("pre_rst_valid", {63'b0, bus.o_valid}, 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'b0, bus.o_valid}, 64'd0);
    check("mid_rst_flags", {60'b0, bus.o_flags}, 64'd0);
    check("mid_rst_cnt",   {48'b0, bus.o_taken_cnt}, 64'd0);
    #1 i_rst_n = 1'b1;
    bus.i_ready = 1'b1;
    drive(1'b1, 64'hC1, 4'h0, 1'b0, 1'b0, 4'h0);
    @(negedge i_clk);
    step();
    check("post_rst_result", bus.o_result, 64'hC1);
    check("post_rst_valid",  {63'b0, bus.o_valid}, 64'd1);

    // Saturation of the taken counter (65537 taken branches)
    drive(1'b1, 64'hD0, 4'h0, 1'b0, 1'b1, 4'b1110);
    repeat (65534) @(posedge i_clk);
    @(negedge i_clk);
    check("cnt_fffe", {48'b0, bus.o_taken_cnt}, 64'hFFFE);
    step();
    check("cnt_ffff", {48'b0, bus.o_taken_cnt}, 64'hFFFF);
    step();
    step();
    check("cnt_sat", {48'b0, bus.o_taken_cnt}, 64'hFFFF);

    drive(1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
